// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one instruction word at a time, holds it
// for the execute stage, then computes the next PC (sequential, branch or
// jump). A fetch that gets no acknowledge for WAIT_LIMIT request cycles
// parks the unit in a sticky FAULT state until reset.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          WAIT_LIMIT = 15
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   output logic [31:0] Instr,
   output logic [5:0]  Op,
   output logic [5:0]  Func,
   output logic        instr_valid,
   input  logic        exec_done,
   input  logic [1:0]  Branch,
   input  logic        jump,
   input  logic        Zero,
   output logic [31:0] PC,
   output logic [31:0] PC_plus4,
   output logic        fault
);

   localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      ISSUE = 2'd2,
      FAULT = 2'd3
   } state_t;

   state_t         state, state_nxt;
   logic           idle_seen;      // set after the first full IDLE cycle
   logic [CW-1:0]  wait_cnt, wait_cnt_nxt, wait_inc;
   logic [31:0]    pc_nxt, instr_nxt;
   logic [31:0]    next_pc, br_off, jump_target;
   logic           taken;

   // Decoder fields and PC arithmetic (all modulo 2^32)
   assign Op          = Instr[31:26];
   assign Func        = Instr[5:0];
   assign imem_addr   = PC;
   assign PC_plus4    = PC + 32'd4;
   assign br_off      = {{14{Instr[15]}}, Instr[15:0], 2'b00};
   assign jump_target = {PC_plus4[31:28], Instr[25:0], 2'b00};
   assign taken       = ((Branch == 2'b01) &  Zero) |
                        ((Branch == 2'b10) & ~Zero);
   assign next_pc     = jump  ? jump_target :
                        taken ? PC_plus4 + br_off : PC_plus4;
   assign wait_inc    = wait_cnt + CW'(1);

   // State register, PC, instruction and wait counter
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; the async reset clears all of it at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         idle_seen <= 1'b0;
         wait_cnt  <= '0;
         PC        <= RESET_PC;
         Instr     <= '0;
      end else begin
         state     <= state_nxt;
         idle_seen <= 1'b1;
         wait_cnt  <= wait_cnt_nxt;
         PC        <= pc_nxt;
         Instr     <= instr_nxt;
      end
   end

   // Next-state and output decode; imem_ack and exec_done only matter in
   // the states that own them
   // NOTE: every output gets a default before the case so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      pc_nxt       = PC;
      instr_nxt    = Instr;
      imem_req     = 1'b0;
      instr_valid  = 1'b0;
      fault        = 1'b0;
      case (state)
         IDLE: begin
            if (idle_seen) state_nxt = REQ;
         end
         REQ: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               instr_nxt    = imem_data;
               wait_cnt_nxt = '0;
               state_nxt    = ISSUE;
            end else begin
               wait_cnt_nxt = wait_inc;
               if (wait_inc == CW'(WAIT_LIMIT)) state_nxt = FAULT;
            end
         end
         ISSUE: begin
            instr_valid = 1'b1;
            if (exec_done) begin
               pc_nxt    = next_pc;
               state_nxt = REQ;
            end
         end
         FAULT: begin
            fault = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter: WAIT_LIMIT, default 15, SHALL be the maximum number of REQ cycles without imem_ack before a fault is declared.
REQ-003 Port: clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port: reset  in  1  SHALL be the reset; it is asynchronous and active-high.
REQ-005 Port: imem_req  out  1  SHALL be the instruction memory request.
REQ-006 Port: imem_addr  out  32  SHALL be the instruction memory byte address.
REQ-007 Port: imem_ack  in  1  SHALL indicate that imem_data is valid this cycle.
REQ-008 Port: imem_data  in  32  SHALL be the instruction word from memory.
REQ-009 Port: Instr  out  32  SHALL be the registered current instruction.
REQ-010 Port: Op  out  6 and Func  out  6 SHALL equal Instr[31:26] and Instr[5:0], feeding the control decoder.
REQ-011 Port: instr_valid  out  1  SHALL indicate that Instr is issued to the execute stage.
REQ-012 Port: exec_done  in  1  SHALL indicate that the execute stage has consumed Instr this cycle.
REQ-013 Port: Branch  in  2, jump  in  1, Zero  in  1  SHALL be decoder and ALU results, sampled only on exec_done.
REQ-014 Port: PC  out  32 and PC_plus4  out  32  SHALL be the current PC and PC+4.
REQ-015 Port: fault  out  1  SHALL be a sticky fetch-timeout flag.

Function
REQ-016 The unit SHALL be a state machine with states IDLE, REQ, ISSUE and FAULT.
REQ-017 IDLE SHALL last one cycle and then transition to REQ.
REQ-018 In REQ: imem_req=1, imem_addr=PC, and the wait counter SHALL increment on each cycle without imem_ack.
REQ-019 On imem_ack in REQ: Instr<=imem_data, counter<=0, next state ISSUE; fetch latency SHALL be one cycle after ack.
REQ-020 If the counter reaches WAIT_LIMIT without ack, the next state SHALL be FAULT (imem_req=0, fault=1), held until reset.
REQ-021 imem_ack outside REQ SHALL be ignored.
REQ-022 In ISSUE: instr_valid=1 and imem_req=0; Instr SHALL be held stable until exec_done.
REQ-023 On exec_done in ISSUE: PC<=next_pc, instr_valid<=0, next state REQ.
REQ-024 exec_done outside ISSUE SHALL be ignored.
REQ-025 next_pc: if jump=1, next_pc SHALL be {PC_plus4[31:28], Instr[25:0], 2'b00}; jump SHALL have priority over branch.
REQ-026 Otherwise, if taken, next_pc SHALL be PC_plus4 + (sign-extended Instr[15:0] << 2), where taken = (Branch==2'b01 & Zero) | (Branch==2'b10 & ~Zero).
REQ-027 Otherwise next_pc SHALL be PC_plus4; Branch==2'b11 SHALL be treated as not taken.
REQ-028 All PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0, and negative offsets wrap.
REQ-029 PC_plus4 SHALL be combinational PC+4.

Reset
REQ-030 Reset SHALL immediately force: state=IDLE, PC=RESET_PC, Instr=0, instr_valid=0, imem_req=0, fault=0, counter=0.
REQ-031 Reset asserted mid-REQ or mid-ISSUE SHALL abort the operation; a pending ack or exec_done in that cycle SHALL be discarded.
REQ-032 After reset deassertion, the first imem_req SHALL rise on the second rising edge (IDLE then REQ).

Verification
REQ-033 Sequential fetch: ack immediately with data 32'h0000_0020 -> instr_valid=1, Op=0, Func=6'h20; exec_done -> PC=4, next imem_addr=4.
REQ-034 BEQ taken: Instr=32'h1000_0003 at PC=8, Branch=01, Zero=1, exec_done -> PC=24; same with Zero=0 -> PC=12.
REQ-035 BNE and jump: Branch=10, Zero=0, imm=16'hFFFF at PC=16 -> PC=16; Instr=32'h0800_0040 with jump=1 at PC=32'h1000_0000 -> PC=32'h1000_0100.
REQ-036 Timeout: hold imem_ack=0 for 15 REQ cycles -> fault=1, imem_req=0; fault persists until reset, then PC=RESET_PC.
REQ-037 Reset mid-fetch: assert reset while imem_req=1 -> imem_req=0 with no clock edge; ack in the same cycle -> Instr stays 0.
REQ-038 Wrap: PC=32'hFFFF_FFFC, not-taken exec_done -> PC=0, imem_addr=0.
